// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select encodings, baud-switch FSM state codes,
// and a counter-width helper.
package uart_pkg;

    localparam int unsigned BAUD_SEL_W   = 2;
    localparam int unsigned ST_W         = 2;
    localparam int unsigned SETTLE_CNT_W = 8;

    localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_9600   = 2'b00;
    localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_19200  = 2'b01;
    localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_115200 = 2'b10;
    localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_256000 = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
    localparam logic [ST_W-1:0] ST_SETTLE = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/baud_switch_ctrl.sv
// Sequences a baud-rate change: hold TX, wait for both paths to drain, switch the
// select, let the generator settle for SETTLE_TICKS ticks, then acknowledge.
module baud_switch_ctrl
    import uart_pkg::*;
#(
    parameter logic [BAUD_SEL_W-1:0] RESET_SEL      = BAUD_SEL_9600,
    parameter int unsigned           SETTLE_TICKS   = 16,
    parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    input  logic [BAUD_SEL_W-1:0] req_sel_i,
    input  logic                  tx_busy_i,
    input  logic                  rx_busy_i,
    input  logic                  baud_en_i,
    output logic [BAUD_SEL_W-1:0] baud_sel_o,
    output logic                  hold_o,
    output logic                  busy_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0]        TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_TICKS - 1);

    logic [ST_W-1:0]         st_q, st_d;
    logic [BAUD_SEL_W-1:0]   sel_r_q, sel_r_d;
    logic [BAUD_SEL_W-1:0]   baud_sel_q, baud_sel_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                    hold_q, hold_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    abort_c;

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q         <= ST_IDLE;
            sel_r_q      <= RESET_SEL;
            baud_sel_q   <= RESET_SEL;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            sel_r_q      <= sel_r_d;
            baud_sel_q   <= baud_sel_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        st_d         = st_q;
        sel_r_d      = sel_r_q;
        baud_sel_d   = baud_sel_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;
        abort_c      = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_sel_i != baud_sel_q) begin
                        sel_r_d   = req_sel_i;
                        tmo_cnt_d = '0;
                        st_d      = ST_DRAIN;
                    end else begin
                        st_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                // A drained cycle takes priority over a coincident timeout.
                if (!tx_busy_i && !rx_busy_i) begin
                    baud_sel_d   = sel_r_q;
                    settle_cnt_d = '0;
                    st_d         = ST_SETTLE;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    abort_c = 1'b1;
                    st_d    = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_SETTLE: begin
                if (baud_en_i) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        st_d = ST_DONE;
                    end
                    if (settle_cnt_q != '1) begin
                        settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
                    end
                end
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    // Outputs follow the next state so they line up with the registered state
    always_comb begin
        hold_d = 1'b0;
        busy_d = 1'b0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        hold_d = (st_d == ST_DRAIN) || (st_d == ST_SETTLE);
        busy_d = (st_d != ST_IDLE);
        ack_d  = (st_d == ST_DONE);
        err_d  = (st_d == ST_DONE) && abort_c;
    end

    assign baud_sel_o = baud_sel_q;
    assign hold_o     = hold_q;
    assign busy_o     = busy_q;
    assign ack_o      = ack_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_baud_switch_ctrl.sv
// Directed bench for baud_switch_ctrl: one instance with timeout disabled for the
// switch/drain/reset flows, a second with a 20-cycle timeout for the abort path.
module tb_baud_switch_ctrl;
    import uart_pkg::*;

    logic       clk;
    logic       rstn;
    logic       a_req, a_tx, a_rx, a_en;
    logic [1:0] a_req_sel;
    logic [1:0] a_sel;
    logic       a_hold, a_busy, a_ack, a_err;
    logic       b_req, b_tx, b_rx, b_en;
    logic [1:0] b_req_sel;
    logic [1:0] b_sel;
    logic       b_hold, b_busy, b_ack, b_err;

    int unsigned n_checks;
    int unsigned n_errors;

    baud_switch_ctrl #(
        .RESET_SEL     (2'b01),
        .SETTLE_TICKS  (4),
        .TIMEOUT_CYCLES(0)
    ) u_dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (a_req),
        .req_sel_i (a_req_sel),
        .tx_busy_i (a_tx),
        .rx_busy_i (a_rx),
        .baud_en_i (a_en),
        .baud_sel_o(a_sel),
        .hold_o    (a_hold),
        .busy_o    (a_busy),
        .ack_o     (a_ack),
        .err_o     (a_err)
    );

    baud_switch_ctrl #(
        .RESET_SEL     (2'b00),
        .SETTLE_TICKS  (4),
        .TIMEOUT_CYCLES(20)
    ) u_dut_to (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (b_req),
        .req_sel_i (b_req_sel),
        .tx_busy_i (b_tx),
        .rx_busy_i (b_rx),
        .baud_en_i (b_en),
        .baud_sel_o(b_sel),
        .hold_o    (b_hold),
        .busy_o    (b_busy),
        .ack_o     (b_ack),
        .err_o     (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [1:0] sel, input logic hold,
                            input logic busy, input logic ack, input logic err);
        check_eq({tag, ".sel"},  32'(a_sel),  32'(sel));
        check_eq({tag, ".hold"}, 32'(a_hold), 32'(hold));
        check_eq({tag, ".busy"}, 32'(a_busy), 32'(busy));
        check_eq({tag, ".ack"},  32'(a_ack),  32'(ack));
        check_eq({tag, ".err"},  32'(a_err),  32'(err));
    endtask

    task automatic expect_b(input string tag, input logic [1:0] sel, input logic hold,
                            input logic busy, input logic ack, input logic err);
        check_eq({tag, ".sel"},  32'(b_sel),  32'(sel));
        check_eq({tag, ".hold"}, 32'(b_hold), 32'(hold));
        check_eq({tag, ".busy"}, 32'(b_busy), 32'(busy));
        check_eq({tag, ".ack"},  32'(b_ack),  32'(ack));
        check_eq({tag, ".err"},  32'(b_err),  32'(err));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Four spaced baud_en pulses in SETTLE; ack is due right after the fourth.
    task automatic settle_and_ack(input string tag, input logic [1:0] sel);
        for (int i = 0; i < 4; i++) begin
            a_en = 1'b1;
            step();
            a_en = 1'b0;
            if (i < 3) expect_a({tag, "_settle"}, sel, 1'b1, 1'b1, 1'b0, 1'b0);
            else       expect_a({tag, "_ack"},    sel, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
            if (i < 3) expect_a({tag, "_gap"},    sel, 1'b1, 1'b1, 1'b0, 1'b0);
            else       expect_a({tag, "_idle"},   sel, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b1;
        a_req = 1'b0; a_req_sel = 2'b00; a_tx = 1'b0; a_rx = 1'b0; a_en = 1'b0;
        b_req = 1'b0; b_req_sel = 2'b00; b_tx = 1'b0; b_rx = 1'b0; b_en = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        expect_a("rst", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_b("rst_b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_a("idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Request for the already-active rate
        a_req = 1'b1; a_req_sel = 2'b01;
        step();
        a_req = 1'b0;
        expect_a("noop_ack", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        expect_a("noop_end", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean switch to 115200 with both paths idle
        a_req = 1'b1; a_req_sel = 2'b10;
        step();
        a_req = 1'b0;
        expect_a("sw_drain", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_a("sw_sel", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        settle_and_ack("sw", 2'b10);

        // Drain wait: TX busy for 50 cycles, RX overlaps and releases later
        a_req = 1'b1; a_req_sel = 2'b11; a_tx = 1'b1;
        step();
        a_req = 1'b0;
        for (int c = 1; c < 50; c++) begin
            if (c == 40) a_rx = 1'b1;
            a_en = (c % 3 == 0);
            expect_a("drain_tx", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        a_tx = 1'b0;
        for (int c = 0; c < 10; c++) begin
            a_en = (c % 2 == 1);
            expect_a("drain_rx", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        a_rx = 1'b0; a_en = 1'b0;
        expect_a("drain_last", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_a("drain_sel", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        settle_and_ack("drain", 2'b11);

        // Drain timeout on the second instance
        b_req = 1'b1; b_req_sel = 2'b10; b_rx = 1'b1;
        step();
        b_req = 1'b0;
        expect_b("to_drain", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            step();
            check_eq("to_wait.ack", 32'(b_ack), 32'd0);
        end
        step();
        expect_b("to_abort", 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        expect_b("to_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        b_rx = 1'b0;

        // Asynchronous reset while settling
        a_req = 1'b1; a_req_sel = 2'b00;
        step();
        a_req = 1'b0;
        step();
        expect_a("ar_settle", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        a_en = 1'b1;
        step();
        a_en = 1'b0;
        #1 rstn = 1'b0;
        #1;
        expect_a("ar_rst", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_en = 1'b1;
            step();
            expect_a("ar_after", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        a_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/baud_switch_ctrl.md
Name: baud_switch_ctrl

Overview:
Controller that sequences baud-rate changes for the UART baud generator. It accepts a baud-change request and holds off new TX frames. It waits for the TX and RX paths to drain, then drives the new 2-bit baud select to the generator. It waits for a programmable number of baud_en ticks before acknowledging, so that no frame is ever sent or received across a rate switch.

Parameters:
RESET_SEL, 2'b00, baud select driven after reset (00=9600, 01=19200, 10=115200, 11=256000)
SETTLE_TICKS, 16, number of baud_en_i pulses counted after the switch before ack; legal range 1..255
TIMEOUT_CYCLES, 1_000_000, max clk cycles spent waiting for drain before abort; 0 disables the timeout

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
req_i  in  1  change request; sampled only in IDLE
req_sel_i  in  2  requested baud select; captured with req_i
tx_busy_i  in  1  TX frame in progress
rx_busy_i  in  1  RX frame in progress
baud_en_i  in  1  single-cycle sample tick from the baud generator
baud_sel_o  out  2  registered select to the baud generator
hold_o  out  1  TX must not start a new frame while high
busy_o  out  1  controller not in IDLE; req_i is ignored
ack_o  out  1  one-cycle pulse at request completion
err_o  out  1  one-cycle pulse coincident with ack_o when the request aborted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: baud_sel_o=RESET_SEL, hold_o=0, busy_o=0, ack_o=0, err_o=0, state=IDLE, counters=0.
- Reset mid-operation aborts immediately. No ack is issued and baud_sel_o returns to RESET_SEL.
- States: IDLE, DRAIN, SETTLE, DONE.
- IDLE, req_i=1 and req_sel_i!=baud_sel_o:
  - latch req_sel_i into sel_r and clear the timeout counter;
  - next state DRAIN; hold_o=1 and busy_o=1 from the following cycle.
- IDLE, req_i=1 and req_sel_i==baud_sel_o: no-op. Next state DONE with err=0 and no hold. ack_o appears 1 cycle after the request edge.
- DRAIN, tx_busy_i=0 and rx_busy_i=0 in the same cycle:
  - baud_sel_o<=sel_r and clear the settle counter;
  - next state SETTLE.
- DRAIN timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while still busy, go to DONE with err=1. baud_sel_o is left unchanged.
- Drain and timeout in the same cycle: drain wins and the switch proceeds.
- SETTLE:
  - count baud_en_i pulses, starting with the cycle after baud_sel_o updates; the generator's realignment pulse counts;
  - on the SETTLE_TICKS-th pulse, next state DONE with err=0;
  - the settle counter is 8 bits and does not wrap.
- DONE: lasts exactly one cycle. ack_o=1, err_o=err flag, hold_o=0, busy_o=1. Next state IDLE.
- hold_o is high only in DRAIN and SETTLE.
- busy_o is high in DRAIN, SETTLE and DONE.
- req_i is ignored while busy_o=1. A request asserted in the cycle DONE returns to IDLE is not sampled; it is sampled on the next IDLE cycle if still high.
- rx_busy_i rising during SETTLE is ignored; the peer must respect the switch protocol.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- Latency, no-op path: ack 1 cycle after the request edge.
- Latency, switch with immediate drain: ack = 1 (DRAIN) + 1 + cycles to the SETTLE_TICKS-th baud_en_i + 1.

Decomposition:
- Shared uart_pkg holds:
  - baud select encodings BAUD_SEL_9600/19200/115200/256000 (2-bit), also used by the baud generator;
  - state encoding constants ST_IDLE/ST_DRAIN/ST_SETTLE/ST_DONE (2-bit).
- No sub-module. This block and the baud generator are siblings in the UART top; this block does not instantiate the generator.

Test Plan:
- Reset: hold rstn_i=0 with RESET_SEL=2'b01 -> baud_sel_o=01, all other outputs 0; release, 10 idle cycles -> outputs unchanged.
- No-op request: baud_sel_o=00, pulse req_i with req_sel_i=00 -> ack_o=1 next cycle, err_o=0, hold_o never high.
- Clean switch: SETTLE_TICKS=4, TX/RX idle, req_sel_i=10:
  - hold_o=1 next cycle and baud_sel_o=10 one cycle later;
  - ack_o fires one cycle after the 4th baud_en_i pulse.
- Drain wait: tx_busy_i high for 50 cycles after the request -> baud_sel_o unchanged until tx_busy_i falls, then updates; rx_busy_i gated the same way.
- Timeout: TIMEOUT_CYCLES=20, rx_busy_i stuck high -> ack_o=1 and err_o=1 exactly 20 cycles after DRAIN entry; baud_sel_o unchanged; hold_o low afterwards.
- Async reset in SETTLE: drop rstn_i mid-settle with no clock edge -> outputs return to reset values immediately; no ack after release.
